// File: rtl/snake_move_sched_pkg.sv
// Shared direction encoding and heading helpers for the snake game blocks.
package snake_move_sched_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_TOP   = 2'b00;
  localparam dir_t DIR_RIGHT = 2'b01;
  localparam dir_t DIR_DOWN  = 2'b10;
  localparam dir_t DIR_LEFT  = 2'b11;

  localparam int QUEUE_DEPTH = 2;

  // Opposite headings differ only in the upper bit of the code.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

// File: rtl/snake_move_sched_if.sv
// Key, control and heading signals between the game top level and the move scheduler.
interface snake_move_sched_if;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       run;
  logic       pause;
  logic [1:0] direction;
  logic       move_tick;
  logic [1:0] queue_level;
  logic       dropped;

  modport master (
    output key_up, key_down, key_left, key_right, run, pause,
    input  direction, move_tick, queue_level, dropped
  );

  modport slave (
    input  key_up, key_down, key_left, key_right, run, pause,
    output direction, move_tick, queue_level, dropped
  );
endinterface

// File: rtl/snake_move_sched_key_debounce.sv
// One key: 2-FF synchronizer, level debouncer and registered rising-edge press pulse.
module key_debounce #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1    <= key_raw;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      // A new level must persist DEB_CYCLES consecutive cycles; any bounce restarts the count.
      if (sync2 != stable) begin
        if (cnt == DEB_LAST) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/snake_move_sched.sv
// Snake move scheduler: debounced keys feed a 2-deep turn queue drained one entry per move tick.
module snake_move_sched
  import snake_move_sched_pkg::*;
#(
  parameter int TICK_DIV   = 25_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic                 clk,
  input  logic                 rst,
  snake_move_sched_if.slave    bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [3:0]    key_raw;
  logic [3:0]    press;
  logic          single;
  dir_t          cmd;
  dir_t          tail_dir;
  dir_t          dir_q;
  dir_t          head_q;
  dir_t          tail_q;
  logic [1:0]    level;
  logic [TW-1:0] tick_cnt;
  logic          tick_now;
  logic          pop;
  logic          push;
  logic          flush;
  logic          run_q;
  logic          move_tick_q;
  logic          dropped_q;

  // Bit index equals the direction code, so the decoded one-hot maps straight to a heading.
  assign key_raw = {bus.key_left, bus.key_down, bus.key_right, bus.key_up};

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key (
      .clk     (clk),
      .rst     (rst),
      .key_raw (key_raw[i]),
      .press   (press[i])
    );
  end

  always_comb begin
    single = 1'b0;
    cmd    = DIR_TOP;
    case (press)
      4'b0001: begin single = 1'b1; cmd = DIR_TOP;   end
      4'b0010: begin single = 1'b1; cmd = DIR_RIGHT; end
      4'b0100: begin single = 1'b1; cmd = DIR_DOWN;  end
      4'b1000: begin single = 1'b1; cmd = DIR_LEFT;  end
      default: ;
    endcase
  end

  always_comb begin
    tail_dir = dir_q;
    if (level == 2'd2)      tail_dir = tail_q;
    else if (level == 2'd1) tail_dir = head_q;
  end

  assign tick_now = bus.run && !bus.pause && (tick_cnt == TICK_LAST);
  assign pop      = tick_now && (level != 2'd0);
  // The queue survives while idle so the first turn can be pre-loaded; it is cleared when a game stops.
  assign flush    = run_q && !bus.run;
  assign push     = single && !flush
                    && (cmd != tail_dir) && !is_reverse(cmd, tail_dir)
                    && ((level != 2'(QUEUE_DEPTH)) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt    <= '0;
      move_tick_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      run_q <= bus.run;
      if (!bus.run) begin
        tick_cnt    <= '0;
        move_tick_q <= 1'b0;
      end else if (bus.pause) begin
        move_tick_q <= 1'b0;
      end else if (tick_cnt == TICK_LAST) begin
        tick_cnt    <= '0;
        move_tick_q <= 1'b1;
      end else begin
        tick_cnt    <= tick_cnt + TW'(1);
        move_tick_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q <= DIR_TOP;
    end else if (!bus.run) begin
      dir_q <= DIR_TOP;
    end else if (pop) begin
      dir_q <= head_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= DIR_TOP;
      tail_q <= DIR_TOP;
      level  <= 2'd0;
    end else if (flush) begin
      level <= 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          // Pop and push together: the level is unchanged, the entries shift by one.
          if (level == 2'd2) begin
            head_q <= tail_q;
            tail_q <= cmd;
          end else begin
            head_q <= cmd;
          end
        end
        2'b01: begin
          head_q <= tail_q;
          level  <= level - 2'd1;
        end
        2'b10: begin
          if (level == 2'd0) head_q <= cmd;
          else               tail_q <= cmd;
          level <= level + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dropped_q <= 1'b0;
    else     dropped_q <= single && !push && !flush;
  end

  assign bus.direction   = dir_q;
  assign bus.move_tick   = move_tick_q;
  assign bus.queue_level = level;
  assign bus.dropped     = dropped_q;

endmodule

// File: tb/tb_snake_move_sched.sv
// Directed bench for snake_move_sched with TICK_DIV=8 and DEB_CYCLES=4.
module tb_snake_move_sched;

  localparam int TICK_DIV   = 8;
  localparam int DEB_CYCLES = 4;

  localparam logic [3:0] K_UP    = 4'b0001;
  localparam logic [3:0] K_RIGHT = 4'b0010;
  localparam logic [3:0] K_DOWN  = 4'b0100;
  localparam logic [3:0] K_LEFT  = 4'b1000;

  typedef struct {
    logic [3:0] keys;
    int         hold;
    logic [1:0] exp_level;
    int         exp_drops;
    logic [1:0] exp_dir;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  snake_move_sched_if bus();

  snake_move_sched #(
    .TICK_DIV   (TICK_DIV),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int drops   = 0;
  int ticks   = 0;

  // driver tasks
  task automatic set_keys(input logic [3:0] m);
    bus.key_up    = m[0];
    bus.key_right = m[1];
    bus.key_down  = m[2];
    bus.key_left  = m[3];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.dropped)   drops++;
    if (bus.move_tick) ticks++;
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.move_tick && n < 40);
    check("tick_timeout", 32'(bus.move_tick), 32'd1);
  endtask

  vec_t vecs[9];
  int   n;

  initial begin
    rst = 1'b1;
    bus.run   = 1'b0;
    bus.pause = 1'b0;
    set_keys(4'b0);

    vecs[0] = '{K_DOWN,          10, 2'd0, 1, 2'b00};  // reverse of TOP
    vecs[1] = '{K_UP,            10, 2'd0, 1, 2'b00};  // same as tail
    vecs[2] = '{K_UP | K_LEFT,   10, 2'd0, 0, 2'b00};  // simultaneous presses ignored
    vecs[3] = '{K_LEFT,           2, 2'd0, 0, 2'b00};  // glitch filtered
    vecs[4] = '{K_LEFT,          10, 2'd1, 0, 2'b00};
    vecs[5] = '{K_RIGHT,         10, 2'd1, 1, 2'b00};  // reverse of queued LEFT
    vecs[6] = '{K_DOWN,          10, 2'd2, 0, 2'b00};
    vecs[7] = '{K_UP,            10, 2'd2, 1, 2'b00};  // reverse of queued DOWN
    vecs[8] = '{K_RIGHT,         10, 2'd2, 1, 2'b00};  // queue full

    repeat (3) step();
    check("rst_dir",     32'(bus.direction),   32'd0);
    check("rst_level",   32'(bus.queue_level), 32'd0);
    check("rst_tick",    32'(bus.move_tick),   32'd0);
    check("rst_dropped", 32'(bus.dropped),     32'd0);
    rst = 1'b0;

    // run with a RIGHT turn, then reset asynchronously mid-run
    bus.run = 1'b1;
    set_keys(K_RIGHT);
    repeat (10) step();
    set_keys(4'b0);
    repeat (10) step();
    check("midrun_dir",   32'(bus.direction),   32'd1);
    check("midrun_level", 32'(bus.queue_level), 32'd0);
    #3 rst = 1'b1;
    #1;
    check("async_rst_dir",   32'(bus.direction),   32'd0);
    check("async_rst_level", 32'(bus.queue_level), 32'd0);
    check("async_rst_tick",  32'(bus.move_tick),   32'd0);
    bus.run = 1'b0;
    step();
    step();
    rst = 1'b0;

    // idle: no ticks while run is low
    ticks = 0;
    repeat (20) step();
    check("idle_ticks", 32'(ticks), 32'd0);
    check("idle_level", 32'(bus.queue_level), 32'd0);

    // table vectors, pre-loading the queue while idle
    for (int i = 0; i < 9; i++) begin
      drops = 0;
      set_keys(vecs[i].keys);
      repeat (vecs[i].hold) step();
      set_keys(4'b0);
      repeat (10) step();
      check($sformatf("vec%0d_level", i), 32'(bus.queue_level), 32'(vecs[i].exp_level));
      check($sformatf("vec%0d_drops", i), 32'(drops),           32'(vecs[i].exp_drops));
      check($sformatf("vec%0d_dir", i),   32'(bus.direction),   32'(vecs[i].exp_dir));
    end

    // start the game: queued LEFT then DOWN are committed on successive ticks
    bus.run = 1'b1;
    wait_tick(n);
    check("first_tick_latency", 32'(n), 32'd8);
    check("tick1_dir",   32'(bus.direction),   32'd3);
    check("tick1_level", 32'(bus.queue_level), 32'd1);
    step();
    check("tick_one_cycle", 32'(bus.move_tick), 32'd0);
    wait_tick(n);
    check("tick2_period", 32'(n), 32'd7);
    check("tick2_dir",    32'(bus.direction),   32'd2);
    check("tick2_level",  32'(bus.queue_level), 32'd0);

    // single turn: push lands on the tick edge with an empty queue, commits next tick
    drops = 0;
    set_keys(K_RIGHT);
    repeat (8) step();
    check("single_push_tick",  32'(bus.move_tick),   32'd1);
    check("single_push_level", 32'(bus.queue_level), 32'd1);
    check("single_push_dir",   32'(bus.direction),   32'd2);
    repeat (2) step();
    set_keys(4'b0);
    wait_tick(n);
    check("single_commit_wait",  32'(n), 32'd6);
    check("single_commit_dir",   32'(bus.direction),   32'd1);
    check("single_commit_level", 32'(bus.queue_level), 32'd0);
    check("single_drops",        32'(drops), 32'd0);

    // pause mid-count
    repeat (3) step();
    bus.pause = 1'b1;
    ticks = 0;
    repeat (30) step();
    check("pause_ticks", 32'(ticks), 32'd0);
    bus.pause = 1'b0;
    wait_tick(n);
    check("pause_resume_wait", 32'(n), 32'd5);
    wait_tick(n);
    check("pause_after_period", 32'(n), 32'd8);

    // fill the queue while paused, then land a push on a tick edge
    bus.pause = 1'b1;
    ticks = 0;
    set_keys(K_DOWN);
    repeat (10) step();
    set_keys(4'b0);
    repeat (10) step();
    set_keys(K_LEFT);
    repeat (10) step();
    set_keys(4'b0);
    repeat (10) step();
    check("fill_level",  32'(bus.queue_level), 32'd2);
    check("fill_ticks",  32'(ticks), 32'd0);
    drops = 0;
    set_keys(K_UP);
    bus.pause = 1'b0;
    repeat (8) step();
    check("pushpop_tick",  32'(bus.move_tick),   32'd1);
    check("pushpop_dir",   32'(bus.direction),   32'd2);
    check("pushpop_level", 32'(bus.queue_level), 32'd2);
    check("pushpop_drops", 32'(drops), 32'd0);
    repeat (2) step();
    set_keys(4'b0);
    wait_tick(n);
    check("drain1_wait",  32'(n), 32'd6);
    check("drain1_dir",   32'(bus.direction),   32'd3);
    check("drain1_level", 32'(bus.queue_level), 32'd1);
    wait_tick(n);
    check("drain2_dir",   32'(bus.direction),   32'd0);
    check("drain2_level", 32'(bus.queue_level), 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
